// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with a first-word-fall-through byte FIFO.
// It decodes the serial line driven by the SoC UART TX pad and queues the
// received bytes for a downstream consumer.
//
// Ports:
//   clk_i        sole clock
//   rst_ni       synchronous active-low reset
//   rx_i         serial line, idle high, asynchronous to clk_i
//   data_o       FIFO head byte; reads as 0 while the FIFO is empty
//   valid_o      FIFO non-empty
//   ready_i      consumer accepts the head (pop on valid_o & ready_i)
//   fill_o       FIFO occupancy
//   frame_err_o  one-cycle pulse when a stop bit is sampled low
//   overflow_o   one-cycle pulse when a good byte is dropped on a full FIFO
module uart_rx_fifo #(
  parameter int unsigned ClkFreq   = 500_000,
  parameter int unsigned Baud      = 115_200,
  parameter int unsigned FifoDepth = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           rx_i,
  output logic [7:0]                     data_o,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [$clog2(FifoDepth+1)-1:0] fill_o,
  output logic                           frame_err_o,
  output logic                           overflow_o
);

  localparam int unsigned ClksPerBit = ClkFreq / Baud;
  localparam int unsigned Half       = ClksPerBit / 2;
  localparam int unsigned CntW       = (ClksPerBit > 2) ? $clog2(ClksPerBit) : 1;
  localparam int unsigned PtrW       = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned FillW      = $clog2(FifoDepth + 1);

  if (ClksPerBit < 2) begin : g_bad_cpb
    $error("uart_rx_fifo: ClkFreq/Baud must be at least 2");
  end
  if (FifoDepth < 1) begin : g_bad_depth
    $error("uart_rx_fifo: FifoDepth must be at least 1");
  end

  localparam logic [CntW-1:0] HalfM1 = CntW'(Half - 1);
  localparam logic [CntW-1:0] BitM1  = CntW'(ClksPerBit - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_e;

  // ---------------- synchronizer ----------------
  logic [1:0] rx_sync;
  logic       rx_s;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) rx_sync <= 2'b11;
    else         rx_sync <= {rx_sync[0], rx_i};
  end
  assign rx_s = rx_sync[1];

  // ---------------- receive FSM ----------------
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            push, frame_err;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      IDLE: if (!rx_s) begin
        state_d = START;
        cnt_d   = '0;
      end
      // Re-check the start bit at its middle; a short low pulse is a glitch.
      START: if (cnt_q == HalfM1) begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = DATA;
          bit_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
      // LSB arrives first, so shift in from the top.
      DATA: if (cnt_q == BitM1) begin
        cnt_d   = '0;
        shift_d = {rx_s, shift_q[7:1]};
        if (bit_q == 3'd7) state_d = STOP;
        else               bit_d   = bit_q + 3'd1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
      STOP: if (cnt_q == BitM1) begin
        cnt_d = '0;
        if (rx_s) begin
          push    = 1'b1;
          state_d = IDLE;
        end else begin
          frame_err = 1'b1;
          state_d   = BREAK;
        end
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
      // Hold here until the line returns high so a held-low line reports once.
      BREAK: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FIFO ----------------
  logic [7:0]       mem [FifoDepth];
  logic [PtrW-1:0]  wr_ptr, rd_ptr;
  logic [FillW-1:0] fill_q;
  logic             full, pop, wr_en;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FifoDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full    = (fill_q == FillW'(FifoDepth));
  assign valid_o = (fill_q != '0);
  assign pop     = valid_o & ready_i;
  // A simultaneous pop frees the slot, so a push on a full FIFO still lands.
  assign wr_en   = push & (~full | pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)   rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_en, pop})
        2'b10:   fill_q <= fill_q + FillW'(1);
        2'b01:   fill_q <= fill_q - FillW'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && wr_en) mem[wr_ptr] <= shift_q;
  end

  assign data_o      = valid_o ? mem[rd_ptr] : 8'h00;
  assign fill_o      = fill_q;
  assign frame_err_o = frame_err & rst_ni;
  assign overflow_o  = push & full & ~pop & rst_ni;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo at 4 clocks per bit, depth 8.
module tb_uart_rx_fifo;
  localparam int CPB = 4;

  logic       clk_i = 1'b0;
  logic       rst_ni, rx_i, ready_i;
  logic [7:0] data_o;
  logic       valid_o, frame_err_o, overflow_o;
  logic [3:0] fill_o;

  uart_rx_fifo #(.ClkFreq(500_000), .Baud(115_200), .FifoDepth(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rx_i(rx_i), .data_o(data_o),
    .valid_o(valid_o), .ready_i(ready_i), .fill_o(fill_o),
    .frame_err_o(frame_err_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_pass = 0;
  int ferr_cnt = 0, ovf_cnt = 0, both_cnt = 0;

  // Pulse tallies, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (frame_err_o === 1'b1) ferr_cnt++;
    if (overflow_o === 1'b1) ovf_cnt++;
    if (frame_err_o === 1'b1 && overflow_o === 1'b1) both_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Advance n clock edges and land 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Drives start, 8 data bits LSB first, stop. Returns at the start of the
  // stop-sample cycle (t+40), leaving the line at the stop-bit value.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_i = bits[i];
      tick(CPB);
    end
  endtask

  task automatic pop_chk(input string name, input logic [7:0] exp);
    ready_i = 1'b1;
    @(negedge clk_i);
    chk({name, "_valid"}, valid_o, 1'b1);
    chk({name, "_data"}, data_o, exp);
    tick(1);
    ready_i = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [3:0] exp_fill;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int f0, o0;
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 4'd1, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 4'd1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 4'd1, 1'b0};
    vecs[3] = '{8'h80, 1'b1, 1'b1, 8'h80, 4'd1, 1'b0};
    vecs[4] = '{8'h01, 1'b1, 1'b1, 8'h01, 4'd1, 1'b0};
    vecs[5] = '{8'h3C, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1};
    vecs[6] = '{8'hC3, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1};
    vecs[7] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 4'd1, 1'b0};

    rst_ni = 1'b0; rx_i = 1'b1; ready_i = 1'b0;

    // Reset
    tick(3);
    @(negedge clk_i);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_fill", fill_o, 4'd0);
    chk("rst_data", data_o, 8'h00);
    tick(1);
    rst_ni = 1'b1;
    tick(20);
    @(negedge clk_i);
    chk("idle_valid", valid_o, 1'b0);
    chk("idle_fill", fill_o, 4'd0);
    chk("idle_data", data_o, 8'h00);
    chk("idle_pulses", ferr_cnt + ovf_cnt, 0);
    tick(1);

    // Single-frame vectors: stop sample at t+40, byte visible at t+41
    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].data, vecs[i].stop);
      rx_i = 1'b1;
      @(negedge clk_i);
      chk($sformatf("v%0d_ferr", i), frame_err_o, vecs[i].exp_ferr);
      chk($sformatf("v%0d_pre_valid", i), valid_o, 1'b0);
      tick(1);
      @(negedge clk_i);
      chk($sformatf("v%0d_valid", i), valid_o, vecs[i].exp_valid);
      chk($sformatf("v%0d_data", i), data_o, vecs[i].exp_data);
      chk($sformatf("v%0d_fill", i), fill_o, vecs[i].exp_fill);
      tick(1);
      if (vecs[i].exp_valid) begin
        ready_i = 1'b1;
        tick(1);
        ready_i = 1'b0;
        @(negedge clk_i);
        chk($sformatf("v%0d_popped_valid", i), valid_o, 1'b0);
        chk($sformatf("v%0d_popped_fill", i), fill_o, 4'd0);
        tick(1);
      end
      tick(6);
    end
    chk("vec_ferr_total", ferr_cnt, 2);

    // One-cycle glitch
    f0 = ferr_cnt;
    rx_i = 1'b0;
    tick(1);
    rx_i = 1'b1;
    tick(20);
    @(negedge clk_i);
    chk("glitch_fill", fill_o, 4'd0);
    chk("glitch_ferr", ferr_cnt - f0, 0);
    tick(1);

    // Bad stop then held-low line: exactly one frame error
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    tick(50);
    @(negedge clk_i);
    chk("break_ferr_once", ferr_cnt - f0, 1);
    chk("break_fill", fill_o, 4'd0);
    tick(1);
    rx_i = 1'b1;
    tick(10);
    send_frame(8'h11, 1'b1);
    rx_i = 1'b1;
    tick(1);
    pop_chk("after_break", 8'h11);
    tick(5);

    // Overflow: 9 back-to-back bytes into an 8-deep FIFO
    o0 = ovf_cnt;
    for (int b = 0; b < 9; b++) send_frame(8'(b), 1'b1);
    rx_i = 1'b1;
    @(negedge clk_i);
    chk("ovf_pulse", overflow_o, 1'b1);
    chk("ovf_no_ferr", frame_err_o, 1'b0);
    tick(1);
    @(negedge clk_i);
    chk("ovf_fill", fill_o, 4'd8);
    chk("ovf_count", ovf_cnt - o0, 1);
    tick(1);
    for (int b = 0; b < 8; b++) pop_chk($sformatf("ovf_drain%0d", b), 8'(b));
    @(negedge clk_i);
    chk("ovf_empty", valid_o, 1'b0);
    tick(5);

    // Full FIFO with a pop in the stop-sample cycle of 0x5A
    o0 = ovf_cnt;
    for (int b = 0; b < 8; b++) send_frame(8'h10 + 8'(b), 1'b1);
    send_frame(8'h5A, 1'b1);
    rx_i = 1'b1;
    ready_i = 1'b1;
    @(negedge clk_i);
    chk("cpop_fill_before", fill_o, 4'd8);
    chk("cpop_no_ovf", overflow_o, 1'b0);
    tick(1);
    ready_i = 1'b0;
    @(negedge clk_i);
    chk("cpop_fill", fill_o, 4'd8);
    chk("cpop_ovf_count", ovf_cnt - o0, 0);
    tick(1);
    for (int b = 1; b < 8; b++) pop_chk($sformatf("cpop_drain%0d", b), 8'h10 + 8'(b));
    pop_chk("cpop_last", 8'h5A);
    @(negedge clk_i);
    chk("cpop_empty", fill_o, 4'd0);
    tick(5);

    // Reset during bit 4 of 0xFF with 3 bytes queued
    for (int b = 0; b < 3; b++) send_frame(8'h31 + 8'(b), 1'b1);
    rx_i = 1'b1;
    tick(5);
    @(negedge clk_i);
    chk("mid_queued", fill_o, 4'd3);
    tick(1);
    f0 = ferr_cnt; o0 = ovf_cnt;
    rx_i = 1'b0;
    tick(CPB);
    rx_i = 1'b1;
    tick(4 * CPB + 1);
    rst_ni = 1'b0;
    tick(1);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("mid_rst_valid", valid_o, 1'b0);
    chk("mid_rst_fill", fill_o, 4'd0);
    tick(40);
    @(negedge clk_i);
    chk("mid_rst_no_byte", fill_o, 4'd0);
    chk("mid_rst_no_pulse", (ferr_cnt - f0) + (ovf_cnt - o0), 0);
    tick(1);
    send_frame(8'h42, 1'b1);
    rx_i = 1'b1;
    tick(1);
    @(negedge clk_i);
    chk("post_rst_fill", fill_o, 4'd1);
    tick(1);
    pop_chk("post_rst", 8'h42);

    chk("never_both", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
